// File: rtl/axi_frame_reader.sv
// Purpose: AXI4 read master that streams one video frame from DDR as INCR bursts into the read-data FIFO.
// Latency: the first AR goes out 2 cycles after frame_start, and each R beat reaches the FIFO 1 cycle after its handshake.
// Backpressure: a burst is issued only when the FIFO level leaves room for it plus margin; rready follows !fifo_full.
module axi_frame_reader #(
    parameter int                    ADDR_WIDTH       = 28,
    parameter int                    DATA_WIDTH       = 256,
    parameter int                    BURST_LEN        = 16,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE       = '0,
    parameter int                    FRAME_BEATS      = 259200,
    parameter int                    FIFO_DEPTH_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        tb_rst,
    input  logic                        frame_start,
    output logic [ADDR_WIDTH-1:0]       araddr,
    output logic [7:0]                  arlen,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [DATA_WIDTH-1:0]       rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data,
    output logic                        fifo_wr_en,
    input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level,
    input  logic                        fifo_full,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        err
);

    // Beats still to request in the current frame.
    localparam int REM_W = $clog2(FRAME_BEATS + 1);
    // Beats in one burst, 1..BURST_LEN.
    localparam int LEN_W = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0]     BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [REM_W-1:0]          REM_INIT   = REM_W'(FRAME_BEATS);
    // The write-side level lags the real occupancy, so a margin of two bursts is kept
    // to guarantee an issued burst always fits and R never needs to stall.
    localparam logic [FIFO_DEPTH_WIDTH:0] LVL_LIMIT  =
        (FIFO_DEPTH_WIDTH + 1)'((1 << FIFO_DEPTH_WIDTH) - 2 * BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [REM_W-1:0]        r_remain;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_beat_cnt;
    logic                    r_pending;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]              r_arlen;
    logic                    r_arvalid;
    logic [DATA_WIDTH-1:0]   r_fifo_wr_data;
    logic                    r_fifo_wr_en;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_err;

    logic [LEN_W-1:0]        w_len;
    logic                    w_room;
    logic                    w_rready;
    logic                    w_r_hs;
    logic                    w_last_in_burst;
    logic                    w_burst_end;
    logic                    w_frame_end;
    logic                    w_overrun;
    logic                    w_beat_err;

    // The burst length is the full burst, or whatever is left of the frame if that is shorter.
    assign w_len = (32'(r_remain) >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(r_remain);
    assign w_room = (fifo_wr_water_level <= LVL_LIMIT);

    // R is accepted only while a burst is outstanding and the FIFO can take the beat.
    assign w_rready        = (r_state == S_DATA) && !fifo_full;
    assign w_r_hs          = rvalid && w_rready;
    assign w_last_in_burst = (r_beat_cnt == (r_len - LEN_W'(1)));
    assign w_burst_end     = w_r_hs && w_last_in_burst;

    // This is the final beat of a frame that was not superseded. A frame_start that arrives
    // on this exact beat is a clean back-to-back frame, not an overrun.
    assign w_frame_end = w_burst_end && (r_remain == '0) && !r_pending;
    assign w_overrun   = frame_start && (r_state != S_IDLE) && !w_frame_end;

    // rlast must appear on exactly the beat the burst counter expects to be last.
    assign w_beat_err  = w_r_hs && ((rresp != 2'b00) || (rlast != w_last_in_burst));

    // Frame sequencer: walks the frame in bursts and handles restarts.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_pending    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arvalid    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_addr   <= FRAME_BASE;
                        r_remain <= REM_INIT;
                        r_busy   <= 1'b1;
                        r_state  <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    // No burst is in flight here, so a restart request takes effect at once.
                    if (frame_start || r_pending) begin
                        r_addr    <= FRAME_BASE;
                        r_remain  <= REM_INIT;
                        r_pending <= 1'b0;
                    end else if (w_room) begin
                        r_len     <= w_len;
                        r_araddr  <= r_addr;
                        r_arlen   <= 8'(w_len - LEN_W'(1));
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    // arvalid is high throughout this state, so arready alone completes the handshake.
                    if (arready) begin
                        r_arvalid  <= 1'b0;
                        r_addr     <= r_addr + ADDR_WIDTH'(r_len) * BEAT_BYTES;
                        r_remain   <= r_remain - REM_W'(r_len);
                        r_beat_cnt <= '0;
                        r_state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                    end
                    if (w_burst_end) begin
                        if (r_pending || (frame_start && (r_remain != '0))) begin
                            // The current frame is abandoned and restarts from its base.
                            r_addr    <= FRAME_BASE;
                            r_remain  <= REM_INIT;
                            r_pending <= 1'b0;
                            r_state   <= S_CHECK;
                        end else if (r_remain == '0) begin
                            r_frame_done <= 1'b1;
                            if (frame_start) begin
                                r_addr   <= FRAME_BASE;
                                r_remain <= REM_INIT;
                                r_state  <= S_CHECK;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end else if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO write port: every accepted R beat is written one cycle later, even an errored one.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_fifo_wr_en   <= 1'b0;
            r_fifo_wr_data <= '0;
        end else begin
            r_fifo_wr_en <= w_r_hs;
            if (w_r_hs) begin
                r_fifo_wr_data <= rdata;
            end
        end
    end

    // Sticky error flag covering bad responses, rlast misplacement and frame overrun.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_err <= 1'b0;
        end else if (w_beat_err || w_overrun) begin
            r_err <= 1'b1;
        end
    end

    assign araddr       = r_araddr;
    assign arlen        = r_arlen;
    assign arvalid      = r_arvalid;
    assign rready       = w_rready;
    assign fifo_wr_data = r_fifo_wr_data;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign err          = r_err;

endmodule

// File: tb/tb_axi_frame_reader.sv
// Bench for axi_frame_reader: a small AXI slave plus FIFO monitor, threshold vector table,
// hand-written corner sequences and randomized frames checked against a burst-plan model.
module tb_axi_frame_reader;
    localparam int AW    = 28;
    localparam int DW    = 256;
    localparam int BL    = 16;
    localparam int FB    = 40;
    localparam int FDW   = 9;
    localparam int BYTES = DW / 8;
    localparam logic [AW-1:0] BASE = '0;

    logic            clk = 1'b0;
    logic            tb_rst;
    logic            frame_start;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_wr_en;
    logic [FDW:0]    fifo_wr_water_level;
    logic            fifo_full;
    logic            busy;
    logic            frame_done;
    logic            err;

    axi_frame_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
        .FRAME_BASE(BASE), .FRAME_BEATS(FB), .FIFO_DEPTH_WIDTH(FDW)
    ) dut (
        .clk(clk), .tb_rst(tb_rst), .frame_start(frame_start),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_water_level(fifo_wr_water_level), .fifo_full(fifo_full),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    typedef struct {
        int lvl;
        bit exp_vld;
    } thr_vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    ar_t           ar_log[$];
    ar_t           exp_ar[$];
    logic [DW-1:0] sent_q[$];
    int            wr_cnt;
    int            done_cnt;

    bit            rnd = 1'b0;
    int            lvl_set = 0;
    int            inj_rlast_burst = -1;
    int            inj_rlast_beat  = -1;
    int            inj_rresp_burst = -1;
    int            inj_rresp_beat  = -1;

    int            bq[$];
    int            beat;
    int            burst_idx;
    bit            hs_ar;
    bit            hs_r;
    int            hs_len;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_dat(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Slave, FIFO monitor and handshake logger, all stepped on the falling edge.
    always @(negedge clk) begin
        if (tb_rst) begin
            bq.delete(); sent_q.delete(); ar_log.delete();
            beat = 0; burst_idx = 0; hs_ar = 0; hs_r = 0; hs_len = 0;
            wr_cnt = 0; done_cnt = 0;
            arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
            fifo_full = 1'b0; fifo_wr_water_level = '0;
        end else begin
            if (fifo_wr_en) begin
                wr_cnt++;
                if (sent_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
                else check_dat("wr_data", fifo_wr_data, sent_q.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                check("done_with_last_wr", 64'(fifo_wr_en), 64'd1);
            end
            if (hs_ar) bq.push_back(hs_len);
            if (hs_r) begin
                beat++;
                if (beat == bq[0]) begin
                    void'(bq.pop_front());
                    beat = 0;
                    burst_idx++;
                end
            end
            arready   = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            fifo_full = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
            fifo_wr_water_level = rnd ? (FDW+1)'($urandom_range(0, 560)) : (FDW+1)'(lvl_set);
            if (!(rvalid && !hs_r)) begin
                if (bq.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                    rvalid = 1'b1;
                    for (int i = 0; i < DW / 32; i++) rdata[i*32 +: 32] = $urandom;
                    rlast = (beat == bq[0] - 1) ||
                            (burst_idx == inj_rlast_burst && beat == inj_rlast_beat);
                    rresp = (burst_idx == inj_rresp_burst && beat == inj_rresp_beat) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
            end
            #1;
            hs_ar = arvalid && arready;
            if (hs_ar) begin
                ar_log.push_back('{araddr, arlen});
                hs_len = int'(arlen) + 1;
            end
            hs_r = rvalid && rready;
            if (hs_r) sent_q.push_back(rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic apply_reset();
        tb_rst = 1'b1;
        tick(); tick();
        tb_rst = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(int bound);
        int start = done_cnt;
        int i = 0;
        while (done_cnt == start && i < bound) begin
            tick();
            i++;
        end
        check("frame_done_timeout", 64'(done_cnt > start), 64'd1);
    endtask

    task automatic wait_wr(int n, int bound);
        int i = 0;
        while (wr_cnt < n && i < bound) begin
            tick();
            i++;
        end
        check("wr_count_timeout", 64'(wr_cnt >= n), 64'd1);
    endtask

    // Burst plan of one frame: consecutive chunks of up to BL beats from BASE.
    task automatic model_frame(int max_bursts);
        int rem = FB;
        int n = 0;
        logic [AW-1:0] a = BASE;
        while (rem > 0 && n < max_bursts) begin
            int len;
            len = (rem < BL) ? rem : BL;
            exp_ar.push_back('{a, 8'(len - 1)});
            a = a + AW'(len * BYTES);
            rem -= len;
            n++;
        end
    endtask

    task automatic check_ar_log(string tag);
        check({tag, "_ar_count"}, 64'(ar_log.size()), 64'(exp_ar.size()));
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
            check($sformatf("%s_araddr[%0d]", tag, i), 64'(ar_log[i].addr), 64'(exp_ar[i].addr));
            check($sformatf("%s_arlen[%0d]", tag, i), 64'(ar_log[i].len), 64'(exp_ar[i].len));
        end
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        check({tag, "_araddr"}, 64'(araddr), 64'd0);
        check({tag, "_arlen"}, 64'(arlen), 64'd0);
        check({tag, "_rready"}, 64'(rready), 64'd0);
        check({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
        check_dat({tag, "_wr_data"}, fifo_wr_data, '0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        thr_vec_t tv[6];
        int seen;
        tv[0] = '{0, 1'b1};
        tv[1] = '{479, 1'b1};
        tv[2] = '{480, 1'b1};
        tv[3] = '{481, 1'b0};
        tv[4] = '{512, 1'b0};
        tv[5] = '{300, 1'b1};

        tb_rst = 1'b1;
        frame_start = 1'b0;
        apply_reset();
        check_idle_outputs("reset");

        // Straight frame: 3 bursts, 40 beats, timing of the first request.
        exp_ar.delete();
        model_frame(100);
        start_frame();
        check("start_busy", 64'(busy), 64'd1);
        check("start_arvalid_n1", 64'(arvalid), 64'd0);
        tick();
        check("start_arvalid_n2", 64'(arvalid), 64'd1);
        check("start_araddr", 64'(araddr), 64'(BASE));
        check("start_arlen", 64'(arlen), 64'd15);
        tick();
        check("rready_after_ar", 64'(rready), 64'd1);
        wait_done(500);
        check("basic_busy_at_done", 64'(busy), 64'd0);
        check("basic_wr_cnt", 64'(wr_cnt), 64'd40);
        check("basic_done_cnt", 64'(done_cnt), 64'd1);
        check("basic_err", 64'(err), 64'd0);
        check_ar_log("basic");

        // Water-level threshold table.
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            lvl_set = tv[i].lvl;
            tick(); tick();
            start_frame();
            tick();
            check($sformatf("thr_arvalid_lvl%0d", tv[i].lvl), 64'(arvalid), 64'(tv[i].exp_vld));
            check($sformatf("thr_arlen_lvl%0d", tv[i].lvl), 64'(arlen), tv[i].exp_vld ? 64'd15 : 64'd0);
        end

        // Level held above the limit, then dropped onto it.
        apply_reset();
        lvl_set = 481;
        tick(); tick();
        start_frame();
        seen = 0;
        repeat (20) begin
            tick();
            if (arvalid) seen++;
        end
        check("hold481_no_arvalid", 64'(seen), 64'd0);
        lvl_set = 480;
        tick();
        check("drop480_arvalid_early", 64'(arvalid), 64'd0);
        tick();
        check("drop480_arvalid", 64'(arvalid), 64'd1);
        lvl_set = 0;

        // Early rlast on the 10th beat of the first burst.
        apply_reset();
        inj_rlast_burst = 0; inj_rlast_beat = 9;
        start_frame();
        wait_done(500);
        check("rlast_err", 64'(err), 64'd1);
        repeat (10) tick();
        check("rlast_err_sticky", 64'(err), 64'd1);
        check("rlast_wr_cnt", 64'(wr_cnt), 64'd40);
        inj_rlast_burst = -1; inj_rlast_beat = -1;
        apply_reset();
        check("rlast_err_cleared", 64'(err), 64'd0);

        // Error response on one beat; that beat still lands in the FIFO.
        inj_rresp_burst = 1; inj_rresp_beat = 3;
        start_frame();
        wait_done(500);
        check("rresp_err", 64'(err), 64'd1);
        check("rresp_wr_cnt", 64'(wr_cnt), 64'd40);
        inj_rresp_burst = -1; inj_rresp_beat = -1;

        // Overrun after 20 beats: the second burst completes, then the frame restarts.
        apply_reset();
        exp_ar.delete();
        model_frame(2);
        model_frame(100);
        start_frame();
        wait_wr(20, 500);
        start_frame();
        check("overrun_err", 64'(err), 64'd1);
        wait_done(500);
        repeat (5) tick();
        check("overrun_done_cnt", 64'(done_cnt), 64'd1);
        check("overrun_wr_cnt", 64'(wr_cnt), 64'd72);
        check_ar_log("overrun");

        // frame_start on the final beat: clean back-to-back frames.
        apply_reset();
        exp_ar.delete();
        model_frame(100);
        model_frame(100);
        start_frame();
        wait_wr(39, 500);
        start_frame();
        check("b2b_frame_done", 64'(frame_done), 64'd1);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_err", 64'(err), 64'd0);
        wait_done(500);
        check("b2b_done_cnt", 64'(done_cnt), 64'd2);
        check("b2b_wr_cnt", 64'(wr_cnt), 64'd80);
        check("b2b_err_end", 64'(err), 64'd0);
        check_ar_log("b2b");

        // Reset in the middle of the second burst.
        apply_reset();
        start_frame();
        wait_wr(20, 500);
        check("midrst_araddr_before", 64'(araddr), 64'h200);
        tb_rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick(); tick();
        tb_rst = 1'b0;
        tick();
        exp_ar.delete();
        model_frame(100);
        start_frame();
        wait_done(500);
        check("midrst_wr_cnt", 64'(wr_cnt), 64'd40);
        check("midrst_done_cnt", 64'(done_cnt), 64'd1);
        check("midrst_err", 64'(err), 64'd0);
        check_ar_log("midrst");

        // Randomized handshakes, FIFO-full stalls and water levels over several frames.
        apply_reset();
        rnd = 1'b1;
        exp_ar.delete();
        for (int f = 0; f < 4; f++) begin
            model_frame(100);
            start_frame();
            wait_done(3000);
            repeat ($urandom_range(0, 5)) tick();
        end
        rnd = 1'b0;
        repeat (5) tick();
        check("rand_wr_cnt", 64'(wr_cnt), 64'(4 * FB));
        check("rand_done_cnt", 64'(done_cnt), 64'd4);
        check("rand_err", 64'(err), 64'd0);
        check("rand_leftover", 64'(sent_q.size()), 64'd0);
        check_ar_log("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
